// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load and busy/done framing.
// Each bit is held for CLKS_PER_BIT cycles; o_serial is registered (latency 1).
module piso_serializer #(
  parameter int WIDTH        = 8,
  parameter bit LSB_FIRST    = 1'b1,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_serial,
  output logic             o_busy,
  output logic             o_done
);

  localparam int BW = $clog2(WIDTH);
  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(CLKS_PER_BIT - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [PW-1:0]    per_q, per_d;
  logic             serial_q, serial_d;
  logic             done_q, done_d;

  logic             load;
  logic             per_wrap;
  logic             last_bit;
  logic             finish;
  logic [WIDTH-1:0] sr_next;
  logic             first_bit;
  logic             next_bit;

  assign load     = (state_q == S_IDLE) && i_valid;
  assign per_wrap = (per_q == PER_LAST);
  assign last_bit = (bit_q == BIT_LAST);
  assign finish   = (state_q == S_SHIFT) && per_wrap && last_bit;

  // Rotate rather than shift so every register bit stays observable.
  always_comb begin
    if (LSB_FIRST) begin
      sr_next   = {sr_q[0], sr_q[WIDTH-1:1]};
      next_bit  = sr_next[0];
      first_bit = i_data[0];
    end else begin
      sr_next   = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
      next_bit  = sr_next[WIDTH-1];
      first_bit = i_data[WIDTH-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_valid) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (finish) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sr_d     = sr_q;
    bit_d    = bit_q;
    per_d    = per_q;
    serial_d = serial_q;
    done_d   = 1'b0;
    if (load) begin
      sr_d     = i_data;
      bit_d    = '0;
      per_d    = '0;
      serial_d = first_bit;
    end else if (state_q == S_SHIFT) begin
      if (!per_wrap) begin
        per_d = per_q + 1'b1;
      end else if (last_bit) begin
        per_d    = '0;
        bit_d    = '0;
        serial_d = 1'b0;
        done_d   = 1'b1;
      end else begin
        per_d    = '0;
        bit_d    = bit_q + 1'b1;
        sr_d     = sr_next;
        serial_d = next_bit;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr_q     <= '0;
      bit_q    <= '0;
      per_q    <= '0;
      serial_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      bit_q    <= bit_d;
      per_q    <= per_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    o_ready  = (state_q == S_IDLE);
    o_busy   = (state_q == S_SHIFT);
    o_serial = serial_q;
    o_done   = done_q;
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench: LSB-first, MSB-first and 3-clocks-per-bit instances
// share clock, reset and data; each has its own load strobe.
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic       va, vb, vc;

  logic ra, sa, ba, da;
  logic rb, sb, bb, db;
  logic rc, sc, bc, dc;

  int tests;
  int fails;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .CLKS_PER_BIT(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(va),
    .o_ready(ra), .o_serial(sa), .o_busy(ba), .o_done(da)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .CLKS_PER_BIT(1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(vb),
    .o_ready(rb), .o_serial(sb), .o_busy(bb), .o_done(db)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .CLKS_PER_BIT(3)) u_c (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(vc),
    .o_ready(rc), .o_serial(sc), .o_busy(bc), .o_done(dc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic r, input logic s,
                       input logic b, input logic d);
    chk({tag, ".ready"},  ra, r);
    chk({tag, ".serial"}, sa, s);
    chk({tag, ".busy"},   ba, b);
    chk({tag, ".done"},   da, d);
  endtask

  logic [7:0] seq;
  logic [7:0] seq_c;

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    data  = 8'h00;
    va    = 1'b0;
    vb    = 1'b0;
    vc    = 1'b0;

    // reset and idle
    step();
    chk_a("rst0", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_a("rst1", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_a("idle", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("idle.b.ready", rb, 1'b1);
      chk("idle.c.ready", rc, 1'b1);
    end

    // LSB-first 0xC1: 1,0,0,0,0,0,1,1
    seq  = 8'b1100_0001;
    data = 8'hC1;
    va   = 1'b1;
    step();
    va   = 1'b0;
    data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk_a("lsb.bit", 1'b0, seq[i], 1'b1, 1'b0);
      step();
    end
    chk_a("lsb.done", 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk_a("lsb.after", 1'b1, 1'b0, 1'b0, 1'b0);

    // MSB-first 0xC1: 1,1,0,0,0,0,0,1
    seq  = 8'b1000_0011;
    data = 8'hC1;
    vb   = 1'b1;
    step();
    vb   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("msb.serial", sb, seq[i]);
      chk("msb.busy",   bb, 1'b1);
      chk("msb.ready",  rb, 1'b0);
      chk("msb.done",   db, 1'b0);
      step();
    end
    chk("msb.done1",  db, 1'b1);
    chk("msb.ready1", rb, 1'b1);
    chk("msb.busy0",  bb, 1'b0);
    step();
    chk("msb.done0",  db, 1'b0);

    // CLKS_PER_BIT=3, 0x02: bit1 high for cycles 3..5 only
    seq_c = 8'b0000_0010;
    data  = 8'h02;
    vc    = 1'b1;
    step();
    vc    = 1'b0;
    data  = 8'hFF;
    for (int i = 0; i < 24; i++) begin
      chk("cpb3.serial", sc, seq_c[i/3]);
      chk("cpb3.busy",   bc, 1'b1);
      chk("cpb3.done",   dc, 1'b0);
      step();
    end
    chk("cpb3.done1",  dc, 1'b1);
    chk("cpb3.ready1", rc, 1'b1);
    chk("cpb3.busy0",  bc, 1'b0);
    step();
    chk("cpb3.done0",  dc, 1'b0);

    // back-to-back with ignored load and data changes during SHIFT
    seq  = 8'b1100_0001;
    data = 8'hC1;
    va   = 1'b1;
    step();
    data = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      chk_a("b2b.first", 1'b0, seq[i], 1'b1, 1'b0);
      step();
    end
    chk_a("b2b.done", 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    va = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_a("b2b.second", 1'b0, 1'b1, 1'b1, 1'b0);
      step();
    end
    chk_a("b2b.done2", 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk_a("b2b.idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // reset mid-word discards the word, no done pulse
    data = 8'hFF;
    va   = 1'b1;
    step();
    va   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_a("mid.bit", 1'b0, 1'b1, 1'b1, 1'b0);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_a("mid.rst", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk_a("mid.nodone", 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // reset wins over a simultaneous load
    rst  = 1'b1;
    va   = 1'b1;
    data = 8'hA5;
    step();
    rst  = 1'b0;
    va   = 1'b0;
    chk_a("rstprio", 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk_a("rstprio.next", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
